booth_mult8_mac_accum: RTL and testbench

Multiply-accumulate back end for the 8-bit radix-4 Booth core. It consumes the core's `product` on each one-cycle `done` pulse and sums a configurable number of products into one frame result, with optional saturation. It presents the result on a valid/ready output with a one-deep hold stage. It gates upstream multiply issue while that hold stage is occupied.

---
 rtl/booth_mult8_mac_accum_pkg.sv | 11 +
 rtl/booth_mult8_sat_add.sv | 24 ++
 rtl/booth_mult8_mac_accum.sv | 106 ++++++++++
 tb/tb_booth_mult8_mac_accum.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/booth_mult8_mac_accum_pkg.sv
// booth_mult8_mac_accum_pkg: shared state encoding and clamp constants for the MAC back end
package booth_mult8_mac_accum_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, ACCUM = 2'b01, HOLD = 2'b10} state_t;
  // Clamp limits built at 64 bits; callers keep the low w bits (w <= 64)
  function automatic logic [63:0] f_sat_max(input int w, input logic sgn);
    return sgn ? (64'd1 << (w - 1)) - 64'd1 : (64'd1 << w) - 64'd1;
  endfunction
  function automatic logic [63:0] f_sat_min(input int w, input logic sgn);
    return sgn ? ~64'd0 << (w - 1) : 64'd0;
  endfunction
endpackage

// File: rtl/booth_mult8_sat_add.sv
// booth_mult8_sat_add: one-term accumulate with signed/unsigned overflow detect and optional clamp
module booth_mult8_sat_add
  import booth_mult8_mac_accum_pkg::*;
#(
  parameter int ACC_WIDTH = 24
) (
  input  logic [ACC_WIDTH-1:0] acc,
  input  logic [ACC_WIDTH-1:0] ext,
  input  logic                 cfg_signed,
  input  logic                 cfg_sat,
  output logic [ACC_WIDTH-1:0] sum,
  output logic                 ovf
);
  localparam logic [63:0] SMAX = f_sat_max(ACC_WIDTH, 1'b1);
  localparam logic [63:0] SMIN = f_sat_min(ACC_WIDTH, 1'b1);
  localparam logic [63:0] UMAX = f_sat_max(ACC_WIDTH, 1'b0);
  logic [ACC_WIDTH:0] wide;
  assign wide = {cfg_signed & acc[ACC_WIDTH-1], acc} + {cfg_signed & ext[ACC_WIDTH-1], ext};
  assign ovf  = cfg_signed ? wide[ACC_WIDTH] ^ wide[ACC_WIDTH-1] : wide[ACC_WIDTH];
  // Top bit of the widened signed sum is the true sign, so it picks the clamp direction
  assign sum  = !(ovf && cfg_sat) ? wide[ACC_WIDTH-1:0] :
                !cfg_signed       ? UMAX[ACC_WIDTH-1:0] :
                wide[ACC_WIDTH]   ? SMIN[ACC_WIDTH-1:0] : SMAX[ACC_WIDTH-1:0];
endmodule

// File: rtl/booth_mult8_mac_accum.sv
// booth_mult8_mac_accum: frames Booth-core products into a saturating/wrapping sum behind a
// one-deep valid/ready hold stage
module booth_mult8_mac_accum
  import booth_mult8_mac_accum_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 24,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_start,
  input  logic [CNT_WIDTH-1:0] cfg_len,
  input  logic                 cfg_signed,
  input  logic                 cfg_sat,
  input  logic [2*WIDTH-1:0]   mult_product,
  input  logic                 mult_done,
  output logic                 can_issue,
  output logic                 busy,
  output logic [ACC_WIDTH-1:0] res_data,
  output logic                 res_overflow,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic                 err_drop
);
  state_t               state;
  logic [CNT_WIDTH-1:0] len_r, cnt;
  logic                 sgn_r, sat_r, ovf_f, ovf, last, out_free;
  logic [ACC_WIDTH-1:0] acc, ext, sum;
  logic [CNT_WIDTH:0]   cnt_next, len_full;
  assign ext       = {{(ACC_WIDTH-2*WIDTH){sgn_r & mult_product[2*WIDTH-1]}}, mult_product};
  assign cnt_next  = {1'b0, cnt} + 1'b1;
  assign len_full  = (len_r == '0) ? {1'b1, {CNT_WIDTH{1'b0}}} : {1'b0, len_r};
  assign last      = cnt_next == len_full;
  assign out_free  = !res_valid || res_ready;
  assign can_issue = state == ACCUM;
  assign busy      = state != IDLE;
  booth_mult8_sat_add #(.ACC_WIDTH(ACC_WIDTH)) u_add (
    .acc(acc), .ext(ext), .cfg_signed(sgn_r), .cfg_sat(sat_r), .sum(sum), .ovf(ovf)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      len_r        <= '0;
      sgn_r        <= 1'b0;
      sat_r        <= 1'b0;
      acc          <= '0;
      cnt          <= '0;
      ovf_f        <= 1'b0;
      res_data     <= '0;
      res_overflow <= 1'b0;
      res_valid    <= 1'b0;
      err_drop     <= 1'b0;
    end else begin
      if (res_valid && res_ready) res_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (mult_done) err_drop <= 1'b1;
          if (frame_start) begin
            len_r <= cfg_len;
            sgn_r <= cfg_signed;
            sat_r <= cfg_sat;
            acc   <= '0;
            cnt   <= '0;
            ovf_f <= 1'b0;
            state <= ACCUM;
          end
        end
        ACCUM: begin
          if (frame_start) begin
            // Restart wins over a coincident product, which is dropped
            if (mult_done) err_drop <= 1'b1;
            len_r <= cfg_len;
            sgn_r <= cfg_signed;
            sat_r <= cfg_sat;
            acc   <= '0;
            cnt   <= '0;
            ovf_f <= 1'b0;
          end else if (mult_done) begin
            acc   <= sum;
            cnt   <= cnt_next[CNT_WIDTH-1:0];
            ovf_f <= ovf_f | ovf;
            if (last && out_free) begin
              res_data     <= sum;
              res_overflow <= ovf_f | ovf;
              res_valid    <= 1'b1;
              state        <= IDLE;
            end else if (last) begin
              state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (mult_done || frame_start) err_drop <= 1'b1;
          if (out_free) begin
            res_data     <= acc;
            res_overflow <= ovf_f;
            res_valid    <= 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_booth_mult8_mac_accum.sv
// tb_booth_mult8_mac_accum: vector table, random frames against an arithmetic model, and
// hand-built backpressure/error/reset sequences
module tb_booth_mult8_mac_accum;
  localparam int AW = 18;
  logic          clk = 1'b0;
  logic          rst, frame_start, cfg_signed, cfg_sat, mult_done, res_ready;
  logic [7:0]    cfg_len;
  logic [15:0]   mult_product;
  logic          can_issue, busy, res_overflow, res_valid, err_drop;
  logic [AW-1:0] res_data;
  int            checks = 0, errors = 0;
  int            pq[$];

  booth_mult8_mac_accum #(.WIDTH(8), .ACC_WIDTH(AW), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .cfg_len(cfg_len),
    .cfg_signed(cfg_signed), .cfg_sat(cfg_sat), .mult_product(mult_product),
    .mult_done(mult_done), .can_issue(can_issue), .busy(busy), .res_data(res_data),
    .res_overflow(res_overflow), .res_valid(res_valid), .res_ready(res_ready),
    .err_drop(err_drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            sgn;
    bit            sat;
    int            len;
    int            prod[5];
    logic [AW-1:0] exp_data;
    bit            exp_ovf;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; frame_start = 1'b0; mult_done = 1'b0; res_ready = 1'b1;
    cfg_len = '0; cfg_signed = 1'b0; cfg_sat = 1'b0; mult_product = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic start_frame(input bit sgn, input bit sat, input int len);
    cfg_signed = sgn; cfg_sat = sat; cfg_len = 8'(len);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic pulse(input int p);
    mult_product = 16'(p);
    mult_done = 1'b1;
    tick();
    mult_done = 1'b0;
  endtask

  // Running sum over the integers, range-checked against the accumulator's numeric range
  task automatic model(input bit sgn, input bit sat, output logic [AW-1:0] d, output bit o);
    longint a, s, p, lo, hi, m;
    int t;
    logic [15:0] t16;
    m  = longint'(1) << AW;
    lo = sgn ? -(m / 2) : 0;
    hi = sgn ? m / 2 - 1 : m - 1;
    a  = 0;
    o  = 1'b0;
    foreach (pq[i]) begin
      t   = pq[i];
      t16 = t[15:0];
      p   = sgn ? longint'($signed(t16)) : longint'(t16);
      s   = a + p;
      if (s > hi || s < lo) begin
        o = 1'b1;
        if (sat) s = (s > hi) ? hi : lo;
        else begin
          s = ((s % m) + m) % m;
          if (s > hi) s = s - m;
        end
      end
      a = s;
    end
    d = AW'(a);
  endtask

  task automatic run_frame(input bit sgn, input bit sat, input int len, input logic [AW-1:0] ed,
                           input bit eo, input string nm);
    start_frame(sgn, sat, len);
    chk({nm, "_can_issue"}, 64'(can_issue), 64'd1);
    foreach (pq[i]) begin
      if (i == pq.size() - 1) chk({nm, "_pre_valid"}, 64'(res_valid), 64'd0);
      pulse(pq[i]);
      if (i < pq.size() - 1) repeat ($urandom_range(0, 2)) tick();
    end
    chk({nm, "_valid"}, 64'(res_valid), 64'd1);
    chk({nm, "_data"}, 64'(res_data), 64'(ed));
    chk({nm, "_ovf"}, 64'(res_overflow), 64'(eo));
    chk({nm, "_idle"}, 64'({busy, can_issue}), 64'd0);
    tick();
  endtask

  initial begin
    vec_t          vt[6];
    logic [AW-1:0] ed;
    bit            eo, sgn, sat;
    int            len;
    vt[0] = '{1, 0, 3, '{100, -50, 7, 0, 0}, 18'd57, 0};
    vt[1] = '{0, 0, 2, '{'hFFFF, 'hFFFF, 0, 0, 0}, 18'h1FFFE, 0};
    vt[2] = '{1, 1, 5, '{32767, 32767, 32767, 32767, 32767}, 18'd131071, 1};
    vt[3] = '{1, 0, 5, '{32767, 32767, 32767, 32767, 32767}, AW'(-98309), 1};
    vt[4] = '{1, 1, 5, '{-32768, -32768, -32768, -32768, -32768}, AW'(-131072), 1};
    vt[5] = '{0, 1, 5, '{'hFFFF, 'hFFFF, 'hFFFF, 'hFFFF, 'hFFFF}, 18'h3FFFF, 1};

    do_reset();
    chk("reset_outputs", 64'({res_data, res_valid, res_overflow, err_drop, busy, can_issue}), 64'd0);

    foreach (vt[k]) begin
      pq.delete();
      for (int i = 0; i < vt[k].len; i++) pq.push_back(vt[k].prod[i]);
      run_frame(vt[k].sgn, vt[k].sat, vt[k].len, vt[k].exp_data, vt[k].exp_ovf,
                $sformatf("vec%0d", k));
    end

    for (int f = 0; f < 20; f++) begin
      sgn = 1'($urandom_range(0, 1));
      sat = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 6);
      pq.delete();
      for (int i = 0; i < len; i++)
        pq.push_back(($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) != 0) ? 'h7FFF : 'h8000)
                                                 : int'($urandom_range(0, 65535)));
      model(sgn, sat, ed, eo);
      run_frame(sgn, sat, len, ed, eo, $sformatf("rand%0d", f));
    end

    // cfg_len 0 selects 256 terms
    pq.delete();
    for (int i = 0; i < 256; i++) pq.push_back(int'($urandom_range(0, 300)));
    model(1'b1, 1'b0, ed, eo);
    run_frame(1'b1, 1'b0, 0, ed, eo, "len0");

    // Backpressure: A sits in the output register, B waits in HOLD
    do_reset();
    res_ready = 1'b0;
    start_frame(1'b0, 1'b0, 1);
    pulse(5);
    chk("bp_a_valid", 64'({res_valid, res_data}), 64'({1'b1, 18'd5}));
    start_frame(1'b0, 1'b0, 1);
    pulse(9);
    chk("bp_hold", 64'({busy, can_issue}), 64'b10);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("bp_start_in_hold_err", 64'({err_drop, busy}), 64'b11);
    tick();
    chk("bp_a_stable", 64'({res_valid, res_data}), 64'({1'b1, 18'd5}));
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("bp_b_loaded", 64'({res_valid, res_data, busy}), 64'({1'b1, 18'd9, 1'b0}));
    res_ready = 1'b1;
    tick();
    chk("bp_b_accepted", 64'(res_valid), 64'd0);

    // Stray done in IDLE, then a normal frame
    do_reset();
    pulse(77);
    chk("idle_done_err", 64'({err_drop, busy}), 64'b10);
    pq = '{3, 4};
    run_frame(1'b1, 1'b0, 2, 18'd7, 1'b0, "after_err");

    // Restart after 2 of 4 terms, with a coincident done on the restart edge
    do_reset();
    start_frame(1'b1, 1'b0, 4);
    pulse(10);
    pulse(20);
    mult_product = 16'd100;
    mult_done = 1'b1;
    frame_start = 1'b1;
    tick();
    mult_done = 1'b0;
    frame_start = 1'b0;
    chk("restart_err", 64'({err_drop, can_issue}), 64'b11);
    pulse(1);
    pulse(2);
    pulse(3);
    chk("restart_not_done", 64'(res_valid), 64'd0);
    pulse(4);
    chk("restart_result", 64'({res_valid, res_data}), 64'({1'b1, 18'd10}));

    // Reset mid-frame, then a late done
    do_reset();
    start_frame(1'b1, 1'b0, 3);
    pulse(11);
    rst = 1'b1;
    frame_start = 1'b1;
    tick();
    rst = 1'b0;
    frame_start = 1'b0;
    chk("midreset_outputs", 64'({res_data, res_valid, res_overflow, err_drop, busy, can_issue}), 64'd0);
    pulse(12);
    chk("late_done_err", 64'({err_drop, busy}), 64'b10);
    pq = '{6, 7};
    run_frame(1'b0, 1'b0, 2, 18'd13, 1'b0, "after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
